point_bank_writer: RTL and testbench

- Parametrised successor to the single-bank coordinate store. Captures a session of (x,y) samples into one bank of a banked point memory, addressed as {bank, sample_index}.
- A session opens on i_start and stays open while i_deny is high. Each accepted sample produces one registered write.
- Adds per-bank full protection, a sticky overflow flag, a session-close summary (count, done pulse) and explicit bank wrap reporting.
- Sits between the coordinate source and the point SRAM write port.

---
 rtl/point_bank_writer_if.sv | 36 +++
 rtl/point_bank_writer.sv | 128 ++++++++++++
 tb/tb_point_bank_writer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/point_bank_writer_if.sv
// Bundle between the coordinate source and point_bank_writer: source-side
// session/sample inputs plus the registered SRAM write port and status.
interface point_bank_writer_if #(
  parameter int COORD_W  = 5,
  parameter int SAMPLE_W = 10,
  parameter int BANK_W   = 5
);
  logic                       i_start;
  logic                       i_deny;
  logic                       i_valid;
  logic [COORD_W-1:0]         i_x;
  logic [COORD_W-1:0]         i_y;
  logic                       o_we;
  logic [COORD_W-1:0]         o_x;
  logic [COORD_W-1:0]         o_y;
  logic [BANK_W+SAMPLE_W-1:0] o_addr;
  logic                       o_busy;
  logic                       o_full;
  logic                       o_ovf;
  logic                       o_done;
  logic [SAMPLE_W:0]          o_count;
  logic [BANK_W-1:0]          o_bank;
  logic                       o_wrap;

  modport master (
    output i_start, i_deny, i_valid, i_x, i_y,
    input  o_we, o_x, o_y, o_addr, o_busy, o_full, o_ovf,
           o_done, o_count, o_bank, o_wrap
  );

  modport slave (
    input  i_start, i_deny, i_valid, i_x, i_y,
    output o_we, o_x, o_y, o_addr, o_busy, o_full, o_ovf,
           o_done, o_count, o_bank, o_wrap
  );
endinterface

// File: rtl/point_bank_writer.sv
// Captures one session of (x,y) samples into a bank of the point memory,
// addressed {bank, index}, with per-bank full protection and close summary.
module point_bank_writer #(
  parameter int COORD_W   = 5,
  parameter int NUM_BANKS = 26,
  parameter int SAMPLE_W  = 10
) (
  input logic               i_clk,
  input logic               i_rst,
  point_bank_writer_if.slave bus
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WORK  = 2'd1;
  localparam logic [1:0] ST_CLOSE = 2'd2;

  localparam logic [SAMPLE_W:0]  DEPTH     = {1'b1, {SAMPLE_W{1'b0}}};
  localparam logic [BANK_W-1:0]  LAST_BANK = BANK_W'(NUM_BANKS - 1);

  logic [1:0]                 state_q, state_d;
  logic [BANK_W-1:0]          bank_q, bank_d;
  logic [SAMPLE_W:0]          index_q, index_d;
  logic                       we_q, we_d;
  logic [COORD_W-1:0]         x_q, x_d;
  logic [COORD_W-1:0]         y_q, y_d;
  logic [BANK_W+SAMPLE_W-1:0] addr_q, addr_d;
  logic                       ovf_q, ovf_d;
  logic                       done_q, done_d;
  logic [SAMPLE_W:0]          count_q, count_d;
  logic                       wrap_q, wrap_d;
  logic                       bankFull;
  logic                       lastBank;

  // Index is one bit wider than the bank depth so "full" is a distinct value
  // and the stored address never spills into the next bank.
  assign bankFull = (index_q == DEPTH);
  assign lastBank = (bank_q == LAST_BANK);

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    index_d = index_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    we_d    = 1'b0;
    x_d     = '0;
    y_d     = '0;
    addr_d  = '0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = ST_WORK;
          index_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_WORK: begin
        if (bus.i_deny) begin
          if (bus.i_valid) begin
            if (!bankFull) begin
              we_d    = 1'b1;
              x_d     = bus.i_x;
              y_d     = bus.i_y;
              addr_d  = {bank_q, index_q[SAMPLE_W-1:0]};
              index_d = index_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else begin
          // Summary is registered here so it is visible during the CLOSE cycle.
          state_d = ST_CLOSE;
          done_d  = 1'b1;
          count_d = index_q;
          wrap_d  = lastBank;
        end
      end
      ST_CLOSE: begin
        state_d = ST_IDLE;
        bank_d  = lastBank ? '0 : bank_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      bank_q  <= '0;
      index_q <= '0;
      we_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      index_q <= index_d;
      we_q    <= we_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.o_we    = we_q;
  assign bus.o_x     = x_q;
  assign bus.o_y     = y_q;
  assign bus.o_addr  = addr_q;
  assign bus.o_busy  = (state_q != ST_IDLE);
  assign bus.o_full  = bankFull;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_done  = done_q;
  assign bus.o_count = count_q;
  assign bus.o_bank  = bank_q;
  assign bus.o_wrap  = wrap_q;
endmodule

// File: tb/tb_point_bank_writer.sv
// Self-checking bench for point_bank_writer: directed sessions from the test
// plan followed by random traffic, all compared against a session-level model.
module tb_point_bank_writer;
  localparam int COORD_W   = 5;
  localparam int NUM_BANKS = 5;
  localparam int SAMPLE_W  = 3;
  localparam int BANK_W    = $clog2(NUM_BANKS);
  localparam int DEPTH     = 1 << SAMPLE_W;
  localparam int ADDR_W    = BANK_W + SAMPLE_W;

  logic clk;
  logic rst;

  point_bank_writer_if #(.COORD_W(COORD_W), .SAMPLE_W(SAMPLE_W), .BANK_W(BANK_W)) bus ();

  point_bank_writer #(
    .COORD_W(COORD_W), .NUM_BANKS(NUM_BANKS), .SAMPLE_W(SAMPLE_W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model of a session: open while deny is high, then one closing cycle.
  bit mOpen, mClosing, mOvf;
  int mBank, mIdx, mCount;
  bit expWe, expDone, expWrap;
  int expX, expY, expAddr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit st, input bit dn, input bit vl,
                           input int x, input int y);
    expWe = 0; expX = 0; expY = 0; expAddr = 0; expDone = 0; expWrap = 0;
    if (r) begin
      mOpen = 0; mClosing = 0; mOvf = 0; mBank = 0; mIdx = 0; mCount = 0;
    end else if (mClosing) begin
      mClosing = 0;
      mBank = (mBank + 1) % NUM_BANKS;
    end else if (mOpen) begin
      if (dn) begin
        if (vl) begin
          if (mIdx < DEPTH) begin
            expWe = 1; expX = x; expY = y;
            expAddr = mBank * DEPTH + mIdx;
            mIdx++;
          end else begin
            mOvf = 1;
          end
        end
      end else begin
        mOpen = 0; mClosing = 1;
        expDone = 1; mCount = mIdx;
        expWrap = (mBank == NUM_BANKS - 1);
      end
    end else if (st) begin
      mOpen = 1; mIdx = 0; mOvf = 0;
    end
  endtask

  task automatic compareAll();
    checkOutput("we",    32'(bus.o_we),    32'(expWe));
    checkOutput("x",     32'(bus.o_x),     32'(expX));
    checkOutput("y",     32'(bus.o_y),     32'(expY));
    checkOutput("addr",  32'(bus.o_addr),  32'(expAddr[ADDR_W-1:0]));
    checkOutput("busy",  32'(bus.o_busy),  32'(mOpen || mClosing));
    checkOutput("full",  32'(bus.o_full),  32'(mIdx == DEPTH));
    checkOutput("ovf",   32'(bus.o_ovf),   32'(mOvf));
    checkOutput("done",  32'(bus.o_done),  32'(expDone));
    checkOutput("count", 32'(bus.o_count), 32'(mCount));
    checkOutput("bank",  32'(bus.o_bank),  32'(mBank));
    checkOutput("wrap",  32'(bus.o_wrap),  32'(expWrap));
  endtask

  // One clock cycle: drive on the falling edge, model the rising edge,
  // compare shortly after it.
  task automatic applyStimulus(input bit r, input bit st, input bit dn, input bit vl,
                               input int x, input int y);
    @(negedge clk);
    rst         = r;
    bus.i_start = st;
    bus.i_deny  = dn;
    bus.i_valid = vl;
    bus.i_x     = COORD_W'(x);
    bus.i_y     = COORD_W'(y);
    @(posedge clk);
    modelStep(r, st, dn, vl, x & ((1 << COORD_W) - 1), y & ((1 << COORD_W) - 1));
    #1;
    compareAll();
  endtask

  int doneSeen, wrapSeen;

  initial begin
    rst = 1'b1;
    bus.i_start = 0; bus.i_deny = 0; bus.i_valid = 0; bus.i_x = '0; bus.i_y = '0;

    $display("[TB] reset and idle");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 7, 9);

    $display("[TB] basic session");
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 1, 2);
    applyStimulus(0, 0, 1, 1, 3, 4);
    applyStimulus(0, 0, 1, 1, 5, 6);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("basicBank", 32'(bus.o_bank), 32'd1);
    checkOutput("basicCount", 32'(bus.o_count), 32'd3);

    $display("[TB] gapped valid and deny-fall edge");
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 10, 11);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 12, 13);
    applyStimulus(0, 0, 1, 1, 14, 15);
    applyStimulus(0, 0, 0, 1, 31, 31);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("gapCount", 32'(bus.o_count), 32'd3);

    $display("[TB] full and overflow");
    applyStimulus(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 1, i, 20 + i);
    checkOutput("fullFlag", 32'(bus.o_full), 32'd1);
    checkOutput("ovfFlag", 32'(bus.o_ovf), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("fullCount", 32'(bus.o_count), 32'(DEPTH));
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("ovfCleared", 32'(bus.o_ovf), 32'd0);
    applyStimulus(0, 0, 1, 1, 17, 18);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] empty sessions through bank wrap");
    doneSeen = 0; wrapSeen = 0;
    for (int s = 0; s < NUM_BANKS; s++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      doneSeen += int'(bus.o_done);
      wrapSeen += int'(bus.o_wrap);
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    checkOutput("emptyDones", 32'(doneSeen), 32'(NUM_BANKS));
    checkOutput("emptyWraps", 32'(wrapSeen), 32'd1);

    $display("[TB] reset mid-session");
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 2, 3);
    applyStimulus(0, 0, 1, 1, 4, 5);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rstBank", 32'(bus.o_bank), 32'd0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 6, 7);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 99) < 88),
                    ($urandom_range(0, 2) != 0),
                    int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
